// File: rtl/mips_cpu_fetch_ctrl_if.sv
// Fetch controller bus: instruction memory read port plus the
// datapath handshake (ir/pc out, exec_done/branch info back in).
interface mips_cpu_fetch_ctrl_if;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        active;
    logic        fault;

    modport master (
        output instr_address, instr_read, ir, ir_valid, pc, active, fault,
        input  instr_waitrequest, instr_readdata,
        input  exec_done, branch_taken, branch_target
    );

    modport slave (
        input  instr_address, instr_read, ir, ir_valid, pc, active, fault,
        output instr_waitrequest, instr_readdata,
        output exec_done, branch_taken, branch_target
    );
endinterface

// File: rtl/mips_cpu_fetch_ctrl.sv
// PC owner / fetch sequencer for the multicycle MIPS core, one delay slot.
// Define ALIGN_CHECK_EN to fault and halt on misaligned branch targets.
module mips_cpu_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input logic                   clk,
    input logic                   rst,
    mips_cpu_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] target_q, target_d;
    logic        ir_valid_q, ir_valid_d;
    logic        active_q, active_d;
    logic        delay_pending_q, delay_pending_d;
    logic [31:0] pc_inc;
    logic [31:0] next_pc;
    logic        bad_redirect;

    assign pc_inc = pc_q + 32'd4;

`ifdef ALIGN_CHECK_EN
    logic fault_q, fault_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    // A pending misaligned target is never loaded; the core stops instead.
    assign bad_redirect = delay_pending_q && (target_q[1:0] != 2'b00);
    assign bus.fault    = fault_q;
`else
    assign bad_redirect = 1'b0;
    assign bus.fault    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            pc_q            <= RESET_VECTOR;
            ir_q            <= 32'd0;
            ir_valid_q      <= 1'b0;
            active_q        <= 1'b1;
            delay_pending_q <= 1'b0;
            target_q        <= 32'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ir_q            <= ir_d;
            ir_valid_q      <= ir_valid_d;
            active_q        <= active_d;
            delay_pending_q <= delay_pending_d;
            target_q        <= target_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ir_d            = ir_q;
        ir_valid_d      = 1'b0;
        active_d        = active_q;
        delay_pending_d = delay_pending_q;
        target_d        = target_q;
        next_pc         = pc_inc;
`ifdef ALIGN_CHECK_EN
        fault_d         = fault_q;
`endif
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (!bus.instr_waitrequest) begin
                    ir_d       = bus.instr_readdata;
                    ir_valid_d = 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (bus.exec_done) begin
                    // A branch sitting in a delay slot is deliberately ignored.
                    if (delay_pending_q) begin
                        delay_pending_d = 1'b0;
                        next_pc         = bad_redirect ? pc_inc : target_q;
                    end else if (bus.branch_taken) begin
                        delay_pending_d = 1'b1;
                        target_d        = bus.branch_target;
`ifdef ALIGN_CHECK_EN
                        if (bus.branch_target[1:0] != 2'b00) begin
                            fault_d = 1'b1;
                        end
`endif
                    end
                    pc_d = next_pc;
                    if (bad_redirect || (next_pc == HALT_ADDR)) begin
                        state_d  = HALTED;
                        active_d = 1'b0;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
        endcase
    end

    assign bus.instr_address = pc_q;
    assign bus.instr_read    = (state_q == FETCH);
    assign bus.ir            = ir_q;
    assign bus.ir_valid      = ir_valid_q;
    assign bus.pc            = pc_q;
    assign bus.active        = active_q;
endmodule

// File: tb/tb_mips_cpu_fetch_ctrl.sv
// Randomized scoreboard bench for mips_cpu_fetch_ctrl: a program-flow
// model predicts every fetch address; a monitor checks fetches and ir.
module tb_mips_cpu_fetch_ctrl;
    localparam logic [31:0] RESET_VEC = 32'hBFC00000;
    localparam logic [31:0] HALT      = 32'h00000000;
`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_cpu_fetch_ctrl_if bus ();

    mips_cpu_fetch_ctrl #(
        .RESET_VECTOR(RESET_VEC),
        .HALT_ADDR   (HALT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;
    int wforce      = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    bit          m_pend;
    bit          m_halted;
    bit          m_fault;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == RESET_VEC) return 32'h24020005;
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pc     = RESET_VEC;
        m_tgt    = 32'd0;
        m_pend   = 1'b0;
        m_halted = 1'b0;
        m_fault  = 1'b0;
        exp_q.delete();
        exp_q.push_back(RESET_VEC);
    endfunction

    // Program-flow view: the instruction after a taken branch runs, then
    // control goes to the remembered target; address 0 means stop.
    function automatic void model_step(input bit bt, input logic [31:0] tg);
        logic [31:0] nxt;
        bit stop;
        stop = 1'b0;
        if (m_pend) begin
            m_pend = 1'b0;
            if (ALIGN && (m_tgt % 4 != 0)) begin
                nxt  = m_pc + 32'd4;
                stop = 1'b1;
            end else begin
                nxt = m_tgt;
            end
        end else begin
            nxt = m_pc + 32'd4;
            if (bt) begin
                m_pend = 1'b1;
                m_tgt  = tg;
                if (ALIGN && (tg % 4 != 0)) m_fault = 1'b1;
            end
        end
        m_pc     = nxt;
        m_halted = stop || (nxt == HALT);
        if (!m_halted) exp_q.push_back(nxt);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.instr_read) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_fetch", bus.instr_address, 32'hFFFFFFFF);
                end else begin
                    chk("fetch_addr", bus.instr_address, exp_q[0]);
                end
            end
            if (bus.ir_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ir_valid", bus.pc, 32'hFFFFFFFF);
                end else begin
                    logic [31:0] a;
                    a = exp_q.pop_front();
                    chk("ir_pc", bus.pc, a);
                    chk("ir_word", bus.ir, mem(a));
                    chk("ir_active", 32'(bus.active), 32'd1);
                end
            end
        end
    end

    task automatic quiet_inputs();
        bus.instr_waitrequest = 1'b0;
        bus.instr_readdata    = 32'd0;
        bus.exec_done         = 1'b0;
        bus.branch_taken      = 1'b0;
        bus.branch_target     = 32'd0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_read"}, 32'(bus.instr_read), 32'd0);
        chk({tag, "_pc"}, bus.pc, RESET_VEC);
        chk({tag, "_ir"}, bus.ir, 32'd0);
        chk({tag, "_irv"}, 32'(bus.ir_valid), 32'd0);
        chk({tag, "_active"}, 32'(bus.active), 32'd1);
        chk({tag, "_fault"}, 32'(bus.fault), 32'd0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst    = 1'b1;
        quiet_inputs();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        model_reset();
        wforce = 3;
        mon_en = 1'b1;
    endtask

    task automatic run(input int n, input int ending);
        int k = 0;
        int dly = 0;
        int cyc = 0;
        bit in_exec = 1'b0;
        bit bt;
        logic [31:0] tg;
        while (!m_halted && !(ending == 3 && k == n)) begin
            @(negedge clk);
            cyc++;
            if (cyc > 4000) begin
                chk("run_timeout", 32'(k), 32'(n));
                return;
            end
            bus.instr_readdata = mem(bus.instr_address);
            if (bus.instr_read && wforce > 0) begin
                bus.instr_waitrequest = 1'b1;
                wforce--;
            end else begin
                bus.instr_waitrequest = ($urandom_range(0, 2) == 0);
            end
            if (bus.ir_valid) begin
                in_exec = 1'b1;
                dly = $urandom_range(0, 2);
            end
            if (in_exec && dly == 0) begin
                if (m_pend) begin
                    bt = rbit();
                    tg = $urandom;
                end else if (k < n - 1) begin
                    bt = ($urandom_range(0, 2) == 0);
                    tg = RESET_VEC + 32'($urandom_range(1, 255)) * 32'd4;
                end else if (k == n - 1) begin
                    bt = 1'b1;
                    case (ending)
                        0: tg = HALT;
                        1: tg = 32'hFFFFFFFC;
                        2: tg = RESET_VEC + 32'h102;
                        default: begin
                            bt = rbit();
                            tg = RESET_VEC + 32'h40;
                        end
                    endcase
                end else begin
                    bt = 1'b1;
                    tg = HALT;
                end
                bus.exec_done     = 1'b1;
                bus.branch_taken  = bt;
                bus.branch_target = tg;
                model_step(bt, tg);
                k++;
                in_exec = 1'b0;
            end else if (in_exec) begin
                dly--;
                bus.exec_done     = 1'b0;
                bus.branch_taken  = rbit();
                bus.branch_target = $urandom;
            end else begin
                bus.exec_done     = rbit();
                bus.branch_taken  = rbit();
                bus.branch_target = $urandom;
            end
        end
    endtask

    task automatic check_halted();
        repeat (12) begin
            @(negedge clk);
            bus.exec_done         = rbit();
            bus.branch_taken      = rbit();
            bus.branch_target     = $urandom;
            bus.instr_waitrequest = rbit();
            chk("halt_read", 32'(bus.instr_read), 32'd0);
            chk("halt_active", 32'(bus.active), 32'd0);
            chk("halt_pc", bus.pc, m_pc);
            chk("halt_irv", 32'(bus.ir_valid), 32'd0);
        end
        chk("fault", 32'(bus.fault), 32'(m_fault));
    endtask

    task automatic mid_fetch_reset();
        @(negedge clk);
        bus.exec_done         = 1'b0;
        bus.instr_waitrequest = 1'b1;
        repeat (2) begin
            @(negedge clk);
            bus.instr_waitrequest = 1'b1;
        end
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check_reset_state("abort");
        rst = 1'b0;
        quiet_inputs();
        model_reset();
        wforce = 0;
        mon_en = 1'b1;
    endtask

    initial begin
        quiet_inputs();
        model_reset();

        do_reset();
        run(6, 0);
        check_halted();

        do_reset();
        run(8, 1);
        check_halted();

        do_reset();
        run(5, 2);
        check_halted();

        do_reset();
        run(4, 3);
        mid_fetch_reset();
        run(5, 0);
        check_halted();

        do_reset();
        run(40, 0);
        check_halted();

        if (exp_q.size() != 0) begin
            chk("leftover_expect", 32'(exp_q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
